muxn_stream: RTL and testbench

//  N-input registered stream multiplexer; parametrised successor of the 2-input datapath mux.
//  Two modes: SEL (external select) and RR (round-robin among valid inputs).
//  One beat per input transfer; valid/ready on every channel; two-entry output skid buffer.

---
 rtl/muxn_pkg.sv | 21 ++
 rtl/muxn_stream_rr_pick.sv | 43 ++++
 rtl/muxn_stream.sv | 151 +++++++++++++++
 tb/tb_muxn_stream.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// ----------------------------------------------------------------------------
// muxn_pkg
//   Shared constants for the N-input registered stream multiplexer.
//   - MODE_SEL / MODE_RR : values of the muxn_stream MODE parameter
//   - N_MIN / N_MAX      : supported channel-count range
//   - sel_w()            : width of the select/grant fields for a given N
// ----------------------------------------------------------------------------
package muxn_pkg;

    localparam int MODE_SEL = 0;   // channel chosen by external select s
    localparam int MODE_RR  = 1;   // round-robin among valid channels

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

    // Select/grant width. N is at least 2, so this is never below 1.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/muxn_stream_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority picker. Scans the request vector starting at
//   the channel after i_ptr (ptr+1, ptr+2, ... modulo N) and reports the first
//   requesting channel.
// Ports
//   i_req     in   N      request per channel
//   i_ptr     in   SELW   last granted channel (scan starts just after it)
//   o_onehot  out  N      one-hot of the picked channel, zero if none
//   o_idx     out  SELW   index of the picked channel, zero if none
//   o_any     out  1      a channel was picked
// ----------------------------------------------------------------------------
module rr_pick
    import muxn_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = sel_w(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic [N-1:0]    o_onehot,
    output logic [SELW-1:0] o_idx,
    output logic            o_any
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; a path that leaves one unassigned infers a latch.
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        // The last offset (N) wraps back onto the pointer itself, so the
        // previously granted channel has the lowest priority.
        for (int off = 1; off <= N; off++) begin
            if (!o_any && i_req[(int'(i_ptr) + off) % N]) begin
                o_any                                  = 1'b1;
                o_onehot[(int'(i_ptr) + off) % N]      = 1'b1;
                o_idx                                  = SELW'((int'(i_ptr) + off) % N);
            end
        end
    end

endmodule

// File: rtl/muxn_stream.sv
// ----------------------------------------------------------------------------
// muxn_stream
//   N-input registered stream multiplexer with valid/ready on every channel.
//   MODE_SEL forwards the channel named by s; MODE_RR round-robins among the
//   valid channels. At most one beat is accepted per cycle. Accepted beats land
//   in the output register (OUT) or, if OUT is stalled, in a one-entry skid
//   register (SKD). ready_in depends only on registered state, s and valid_in,
//   never on ready_out.
// Ports
//   clk        in   1         rising-edge clock
//   reset      in   1         asynchronous, active-low reset
//   d          in   N*WIDTH   channel i data at d[i*WIDTH +: WIDTH]
//   valid_in   in   N         channel i offers a beat
//   ready_in   out  N         channel i beat taken when valid_in[i] & ready_in[i]
//   s          in   SELW      channel to forward (SEL mode only)
//   y          out  WIDTH     output data
//   valid_out  out  1         y holds a beat
//   ready_out  in   1         downstream takes the beat on y
//   grant      out  SELW      source channel of the beat on y
// ----------------------------------------------------------------------------
module muxn_stream
    import muxn_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SELW  = sel_w(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] d,
    input  logic [N-1:0]       valid_in,
    output logic [N-1:0]       ready_in,
    input  logic [SELW-1:0]    s,
    output logic [WIDTH-1:0]   y,
    output logic               valid_out,
    input  logic               ready_out,
    output logic [SELW-1:0]    grant
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  src;
        logic             valid;
    } slot_t;

    slot_t            r_out;
    slot_t            r_skd;

    logic [N-1:0]     w_pick_onehot;
    logic [SELW-1:0]  w_pick_idx;
    logic             w_pick_any;
    logic             w_acc;
    logic             w_drn;
    logic [WIDTH-1:0] w_beat_data;
    slot_t            w_beat;

    // ------------------------------------------------------------------
    // Channel choice
    // ------------------------------------------------------------------
    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] r_ptr;

            rr_pick #(.N(N)) u_pick (
                .i_req    (valid_in),
                .i_ptr    (r_ptr),
                .o_onehot (w_pick_onehot),
                .o_idx    (w_pick_idx),
                .o_any    (w_pick_any)
            );

            // Pointer moves only on an accepted beat, so idle cycles do not
            // disturb the rotation order.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_ptr <= SELW'(N - 1);
                end else if (w_acc) begin
                    r_ptr <= w_pick_idx;
                end
            end
        end else begin : g_sel
            // An s value of N or above (reachable when N is not a power of
            // two) matches no channel, so nothing is ever accepted for it.
            always_comb begin
                w_pick_onehot = '0;
                w_pick_idx    = '0;
                w_pick_any    = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (s == SELW'(i)) begin
                        w_pick_onehot[i] = 1'b1;
                        w_pick_idx       = s;
                        w_pick_any       = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake and beat formation
    // ------------------------------------------------------------------
    // A free SKD guarantees room for one more beat whatever downstream does
    // this cycle, which is what keeps ready_out out of the ready_in path.
    assign ready_in = (w_pick_any && !r_skd.valid && reset) ? w_pick_onehot : '0;
    assign w_acc    = |(ready_in & valid_in);
    assign w_drn    = r_out.valid & ready_out;

    always_comb begin
        w_beat_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick_onehot[i]) begin
                w_beat_data = d[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_beat = '{data: w_beat_data, src: w_pick_idx, valid: w_acc};

    // ------------------------------------------------------------------
    // OUT / SKD registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values; blocking here would create order races.
        if (!reset) begin
            r_out <= '0;
            r_skd <= '0;
        end else if (r_skd.valid) begin
            // SKD full: ready_in is low, so only a drain can move anything.
            if (w_drn) begin
                r_out <= r_skd;
                r_skd <= '0;
            end
        end else if (!r_out.valid || w_drn) begin
            if (w_acc) begin
                r_out <= w_beat;
            end else begin
                r_out.valid <= 1'b0;
            end
        end else if (w_acc) begin
            // OUT stalled: park the new beat behind it.
            r_skd <= w_beat;
        end
    end

    assign y         = r_out.data;
    assign grant     = r_out.src;
    assign valid_out = r_out.valid;

endmodule

// File: tb/tb_muxn_stream.sv
// ----------------------------------------------------------------------------
// tb_muxn_stream
//   Directed bench for muxn_stream. Three instances share clock and reset:
//   u_sel4 (SEL, N=4), u_rr4 (RR, N=4) and u_sel6 (SEL, N=6), all WIDTH=8.
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_muxn_stream;
    import muxn_pkg::*;

    logic clk;
    logic reset;

    // SEL, N=4
    logic [31:0] a_d;
    logic [3:0]  a_vin, a_rin;
    logic [1:0]  a_s, a_grant;
    logic [7:0]  a_y;
    logic        a_vout, a_rout;

    // RR, N=4
    logic [31:0] b_d;
    logic [3:0]  b_vin, b_rin;
    logic [1:0]  b_s, b_grant;
    logic [7:0]  b_y;
    logic        b_vout, b_rout;

    // SEL, N=6
    logic [47:0] c_d;
    logic [5:0]  c_vin, c_rin;
    logic [2:0]  c_s, c_grant;
    logic [7:0]  c_y;
    logic        c_vout, c_rout;

    int errors;
    int checks;

    muxn_stream #(.WIDTH(8), .N(4), .MODE(MODE_SEL)) u_sel4 (
        .clk(clk), .reset(reset), .d(a_d), .valid_in(a_vin), .ready_in(a_rin),
        .s(a_s), .y(a_y), .valid_out(a_vout), .ready_out(a_rout), .grant(a_grant)
    );

    muxn_stream #(.WIDTH(8), .N(4), .MODE(MODE_RR)) u_rr4 (
        .clk(clk), .reset(reset), .d(b_d), .valid_in(b_vin), .ready_in(b_rin),
        .s(b_s), .y(b_y), .valid_out(b_vout), .ready_out(b_rout), .grant(b_grant)
    );

    muxn_stream #(.WIDTH(8), .N(6), .MODE(MODE_SEL)) u_sel6 (
        .clk(clk), .reset(reset), .d(c_d), .valid_in(c_vin), .ready_in(c_rin),
        .s(c_s), .y(c_y), .valid_out(c_vout), .ready_out(c_rout), .grant(c_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held with every channel offering: nothing may be ready.
    task automatic test_reset();
        a_vin = 4'hF; b_vin = 4'hF; c_vin = 6'h3F;
        tick();
        tick();
        checks++; if (a_vout !== 1'b0)  begin errors++; $display("FAIL rst_sel4_vout: got %b want 0", a_vout); end
        checks++; if (a_y !== 8'h00)    begin errors++; $display("FAIL rst_sel4_y: got %h want 00", a_y); end
        checks++; if (a_grant !== 2'd0) begin errors++; $display("FAIL rst_sel4_grant: got %0d want 0", a_grant); end
        checks++; if (a_rin !== 4'h0)   begin errors++; $display("FAIL rst_sel4_ready_in: got %b want 0000", a_rin); end
        checks++; if (b_rin !== 4'h0)   begin errors++; $display("FAIL rst_rr4_ready_in: got %b want 0000", b_rin); end
        checks++; if (b_vout !== 1'b0)  begin errors++; $display("FAIL rst_rr4_vout: got %b want 0", b_vout); end
        checks++; if (c_rin !== 6'h00)  begin errors++; $display("FAIL rst_sel6_ready_in: got %b want 000000", c_rin); end
        a_vin = '0; b_vin = '0; c_vin = '0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_sel_basic();
        a_s = 2'd2; a_d = 32'h00A5_0000; a_vin = 4'b0100; a_rout = 1'b1;
        #1;
        checks++; if (a_rin !== 4'b0100) begin errors++; $display("FAIL sel_ready_in: got %b want 0100", a_rin); end
        tick();
        checks++; if (a_y !== 8'hA5)      begin errors++; $display("FAIL sel_y: got %h want a5", a_y); end
        checks++; if (a_grant !== 2'd2)   begin errors++; $display("FAIL sel_grant: got %0d want 2", a_grant); end
        checks++; if (a_vout !== 1'b1)    begin errors++; $display("FAIL sel_vout: got %b want 1", a_vout); end
        a_vin = 4'b0000;
        tick();
        checks++; if (a_vout !== 1'b0)    begin errors++; $display("FAIL sel_drain_vout: got %b want 0", a_vout); end
    endtask

    task automatic test_backpressure();
        a_s = 2'd1; a_rout = 1'b0; a_d = 32'h0000_1100; a_vin = 4'b0010;
        #1;
        checks++; if (a_rin !== 4'b0010) begin errors++; $display("FAIL bp_ready0: got %b want 0010", a_rin); end
        tick();
        checks++; if (a_y !== 8'h11)     begin errors++; $display("FAIL bp_y_first: got %h want 11", a_y); end
        checks++; if (a_vout !== 1'b1)   begin errors++; $display("FAIL bp_vout_first: got %b want 1", a_vout); end
        a_d = 32'h0000_2200;
        tick();
        checks++; if (a_rin !== 4'b0000) begin errors++; $display("FAIL bp_ready_skd_full: got %b want 0000", a_rin); end
        checks++; if (a_y !== 8'h11)     begin errors++; $display("FAIL bp_y_hold1: got %h want 11", a_y); end
        a_d = 32'h0000_3300;
        tick();
        checks++; if (a_y !== 8'h11)     begin errors++; $display("FAIL bp_y_hold2: got %h want 11", a_y); end
        checks++; if (a_rin !== 4'b0000) begin errors++; $display("FAIL bp_ready_hold: got %b want 0000", a_rin); end
        a_rout = 1'b1;
        tick();
        checks++; if (a_y !== 8'h22)     begin errors++; $display("FAIL bp_y_second: got %h want 22", a_y); end
        checks++; if (a_rin !== 4'b0010) begin errors++; $display("FAIL bp_ready_after_drain: got %b want 0010", a_rin); end
        tick();
        checks++; if (a_y !== 8'h33)     begin errors++; $display("FAIL bp_y_third: got %h want 33", a_y); end
        checks++; if (a_vout !== 1'b1)   begin errors++; $display("FAIL bp_vout_third: got %b want 1", a_vout); end
        a_vin = 4'b0000;
        tick();
        checks++; if (a_vout !== 1'b0)   begin errors++; $display("FAIL bp_empty: got %b want 0", a_vout); end
    endtask

    task automatic test_rr();
        logic [7:0] ey;
        logic [1:0] eg;
        b_rout = 1'b1; b_d = 32'hC3C2_C1C0; b_vin = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            eg = 2'(k % 4);
            ey = 8'hC0 + 8'(k % 4);
            checks++; if (b_grant !== eg) begin errors++; $display("FAIL rr_all_grant[%0d]: got %0d want %0d", k, b_grant, eg); end
            checks++; if (b_y !== ey)     begin errors++; $display("FAIL rr_all_y[%0d]: got %h want %h", k, b_y, ey); end
        end
        // Pointer now 0: sparse requests on channels 0 and 3.
        b_vin = 4'b1001;
        tick();
        checks++; if (b_grant !== 2'd3) begin errors++; $display("FAIL rr_sparse_g3: got %0d want 3", b_grant); end
        checks++; if (b_y !== 8'hC3)    begin errors++; $display("FAIL rr_sparse_y3: got %h want c3", b_y); end
        tick();
        checks++; if (b_grant !== 2'd0) begin errors++; $display("FAIL rr_sparse_g0: got %0d want 0", b_grant); end
        b_vin = 4'b0000;
        tick();
        checks++; if (b_vout !== 1'b0)  begin errors++; $display("FAIL rr_idle_vout: got %b want 0", b_vout); end
        tick();
        b_vin = 4'b1001;
        tick();
        checks++; if (b_grant !== 2'd3) begin errors++; $display("FAIL rr_after_idle_g3: got %0d want 3", b_grant); end
        checks++; if (b_vout !== 1'b1)  begin errors++; $display("FAIL rr_after_idle_vout: got %b want 1", b_vout); end
        b_vin = 4'b0000;
        tick();
    endtask

    task automatic test_sel6();
        c_rout = 1'b1; c_d = 48'h5A00_0000_0000; c_s = 3'd5; c_vin = 6'b100000;
        #1;
        checks++; if (c_rin !== 6'b100000) begin errors++; $display("FAIL sel6_ready5: got %b want 100000", c_rin); end
        tick();
        checks++; if (c_grant !== 3'd5)    begin errors++; $display("FAIL sel6_grant: got %0d want 5", c_grant); end
        checks++; if (c_y !== 8'h5A)       begin errors++; $display("FAIL sel6_y: got %h want 5a", c_y); end
        // Out-of-range selects: nothing accepted even with every channel valid.
        c_s = 3'd6; c_vin = 6'h3F; c_d = 48'h7777_7777_7777;
        #1;
        checks++; if (c_rin !== 6'b000000) begin errors++; $display("FAIL sel6_s6_ready: got %b want 000000", c_rin); end
        tick();
        checks++; if (c_vout !== 1'b0)     begin errors++; $display("FAIL sel6_s6_vout: got %b want 0", c_vout); end
        c_s = 3'd7;
        #1;
        checks++; if (c_rin !== 6'b000000) begin errors++; $display("FAIL sel6_s7_ready: got %b want 000000", c_rin); end
        tick();
        checks++; if (c_vout !== 1'b0)     begin errors++; $display("FAIL sel6_s7_vout: got %b want 0", c_vout); end
        c_vin = '0;
    endtask

    // Leaves u_sel4 with OUT and SKD both full for the async reset test.
    task automatic test_sel_stall();
        a_rout = 1'b0; a_s = 2'd3; a_vin = 4'b1000; a_d = 32'h3300_0000;
        tick();
        checks++; if (a_grant !== 2'd3) begin errors++; $display("FAIL stall_grant0: got %0d want 3", a_grant); end
        checks++; if (a_y !== 8'h33)    begin errors++; $display("FAIL stall_y0: got %h want 33", a_y); end
        a_s = 2'd0; a_vin = 4'b0001; a_d = 32'h3300_0044;
        tick();
        checks++; if (a_grant !== 2'd3) begin errors++; $display("FAIL stall_grant1: got %0d want 3", a_grant); end
        checks++; if (a_y !== 8'h33)    begin errors++; $display("FAIL stall_y1: got %h want 33", a_y); end
        checks++; if (a_rin !== 4'h0)   begin errors++; $display("FAIL stall_ready: got %b want 0000", a_rin); end
        a_s = 2'd1; a_vin = 4'b0010;
        tick();
        checks++; if (a_grant !== 2'd3) begin errors++; $display("FAIL stall_grant2: got %0d want 3", a_grant); end
        checks++; if (a_vout !== 1'b1)  begin errors++; $display("FAIL stall_vout: got %b want 1", a_vout); end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (a_vout !== 1'b0)  begin errors++; $display("FAIL arst_vout: got %b want 0", a_vout); end
        checks++; if (a_y !== 8'h00)    begin errors++; $display("FAIL arst_y: got %h want 00", a_y); end
        checks++; if (a_grant !== 2'd0) begin errors++; $display("FAIL arst_grant: got %0d want 0", a_grant); end
        checks++; if (a_rin !== 4'h0)   begin errors++; $display("FAIL arst_ready: got %b want 0000", a_rin); end
        a_vin = 4'b0000;
        @(negedge clk);
        reset  = 1'b1;
        a_rout = 1'b1;
        tick();
        checks++; if (a_vout !== 1'b0)  begin errors++; $display("FAIL arst_skd_dropped: got %b want 0", a_vout); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        a_d = '0; a_vin = '0; a_s = '0; a_rout = 1'b0;
        b_d = '0; b_vin = '0; b_s = '0; b_rout = 1'b0;
        c_d = '0; c_vin = '0; c_s = '0; c_rout = 1'b0;

        test_reset();
        test_sel_basic();
        test_backpressure();
        test_rr();
        test_sel6();
        test_sel_stall();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
